// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths and the sentinel tag used by the register file.
`default_nettype none

package reg_file_pkg;

  localparam int REG_NUMBER_WIDTH = 5;
  localparam int DATA_WIDTH       = 32;
  localparam int ROB_SIZE         = 16;
  localparam int ROB_ID_WIDTH     = 5;

  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;

  // Tag value one past the last ROB entry marks a committed register.
  localparam rob_id_t NON_DEPENDENT_ID = rob_id_t'(ROB_SIZE);

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// +----------------------------------------------------------------------+
// | reg_file: architectural register file with ROB rename tags           |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_file
  import reg_file_pkg::*;
#(
  parameter int                   REG_NUM       = 32,
  parameter int                   ROB_ID_W      = 5,
  parameter logic [ROB_ID_W-1:0]  NON_DEPENDENT = ROB_ID_W'(ROB_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        enable_from_rob,
  input  logic [DATA_WIDTH-1:0]       V_from_rob,
  input  logic [ROB_ID_W-1:0]         Q_from_rob,
  input  logic                        enable_rename_from_dsp,
  input  logic [REG_NUMBER_WIDTH-1:0] rd_from_dsp,
  input  logic [ROB_ID_W-1:0]         rob_id_from_dsp,
  input  logic [REG_NUMBER_WIDTH-1:0] rs1_from_dsp,
  input  logic [REG_NUMBER_WIDTH-1:0] rs2_from_dsp,
  output logic [DATA_WIDTH-1:0]       Vj_to_dsp,
  output logic [DATA_WIDTH-1:0]       Vk_to_dsp,
  output logic [ROB_ID_W-1:0]         Qj_to_dsp,
  output logic [ROB_ID_W-1:0]         Qk_to_dsp,
  input  logic                        mispredict
);

  logic [DATA_WIDTH-1:0] r_value [REG_NUM];
  logic [ROB_ID_W-1:0]   r_tag   [REG_NUM];

  logic [REG_NUM-1:0] w_hit;
  logic [REG_NUM-1:0] w_ren;
  logic               w_rename_ok;

  assign w_rename_ok = enable_rename_from_dsp && !mispredict;

  // x0 never matches a commit and never accepts a rename.
  for (genvar i = 0; i < REG_NUM; i++) begin : g_match
    if (i == 0) begin : g_zero
      assign w_hit[i] = 1'b0;
      assign w_ren[i] = 1'b0;
    end else begin : g_cmp
      assign w_hit[i] = enable_from_rob && (r_tag[i] == Q_from_rob);
      assign w_ren[i] = w_rename_ok && (rd_from_dsp == REG_NUMBER_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= NON_DEPENDENT;
      end
    end else if (rdy) begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (w_hit[i]) begin
          r_value[i] <= V_from_rob;
        end
        // A same-cycle rename outranks the commit's tag clear.
        if (mispredict) begin
          r_tag[i] <= NON_DEPENDENT;
        end else if (w_ren[i]) begin
          r_tag[i] <= rob_id_from_dsp;
        end else if (w_hit[i]) begin
          r_tag[i] <= NON_DEPENDENT;
        end
      end
    end
  end

  logic [REG_NUMBER_WIDTH-1:0] w_rs [2];
  assign w_rs[0] = rs1_from_dsp;
  assign w_rs[1] = rs2_from_dsp;

  for (genvar p = 0; p < 2; p++) begin : g_read
    logic [DATA_WIDTH-1:0] v;
    logic [ROB_ID_W-1:0]   q;

    always_comb begin
      v = '0;
      q = NON_DEPENDENT;
      if (w_rs[p] != '0) begin
        if (w_hit[w_rs[p]]) begin
          v = V_from_rob;
        end else if (r_tag[w_rs[p]] == NON_DEPENDENT) begin
          v = r_value[w_rs[p]];
        end else begin
          q = r_tag[w_rs[p]];
        end
      end
    end
  end

  assign Vj_to_dsp = g_read[0].v;
  assign Qj_to_dsp = g_read[0].q;
  assign Vk_to_dsp = g_read[1].v;
  assign Qk_to_dsp = g_read[1].q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and randomized checks of reg_file against an array model.
`default_nettype none

module tb_reg_file;

  localparam logic [4:0] ND = 5'd16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        en_c;
  logic [31:0] vc;
  logic [4:0]  qc;
  logic        en_r;
  logic [4:0]  rd;
  logic [4:0]  rid;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        misp;
  logic [31:0] vj;
  logic [31:0] vk;
  logic [4:0]  qj;
  logic [4:0]  qk;

  always #5 clk = ~clk;

  reg_file dut (
    .clk                   (clk),
    .rst                   (rst),
    .rdy                   (rdy),
    .enable_from_rob       (en_c),
    .V_from_rob            (vc),
    .Q_from_rob            (qc),
    .enable_rename_from_dsp(en_r),
    .rd_from_dsp           (rd),
    .rob_id_from_dsp       (rid),
    .rs1_from_dsp          (rs1),
    .rs2_from_dsp          (rs2),
    .Vj_to_dsp             (vj),
    .Vk_to_dsp             (vk),
    .Qj_to_dsp             (qj),
    .Qk_to_dsp             (qk),
    .mispredict            (misp)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];

  function automatic logic [31:0] exp_v(input logic [4:0] rs);
    if (rs == 0) return 32'd0;
    if (en_c && m_tag[rs] == qc) return vc;
    if (m_tag[rs] == ND) return m_val[rs];
    return 32'd0;
  endfunction

  function automatic logic [4:0] exp_q(input logic [4:0] rs);
    if (rs == 0) return ND;
    if (en_c && m_tag[rs] == qc) return ND;
    return m_tag[rs];
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_ports(input string name);
    #1;
    chk({name, ".Vj"}, vj, exp_v(rs1));
    chk({name, ".Qj"}, 32'(qj), 32'(exp_q(rs1)));
    chk({name, ".Vk"}, vk, exp_v(rs2));
    chk({name, ".Qk"}, 32'(qk), 32'(exp_q(rs2)));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'd0;
      m_tag[i] = ND;
    end
  endtask

  // Architectural effect of one clock edge given the inputs currently driven.
  task automatic model_clock();
    int hit;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!rdy) return;
    hit = -1;
    if (en_c)
      for (int i = 1; i < 32; i++)
        if (m_tag[i] == qc) hit = i;
    if (hit >= 0) m_val[hit] = vc;
    if (misp) begin
      for (int i = 0; i < 32; i++) m_tag[i] = ND;
    end else begin
      if (hit >= 0) m_tag[hit] = ND;
      if (en_r && rd != 0) m_tag[rd] = rid;
    end
  endtask

  task automatic idle();
    rdy  = 1'b1;
    en_c = 1'b0;
    vc   = 32'd0;
    qc   = 5'd0;
    en_r = 1'b0;
    rd   = 5'd0;
    rid  = 5'd0;
    misp = 1'b0;
  endtask

  task automatic cyc();
    model_clock();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic rename(input logic [4:0] r, input logic [4:0] id);
    en_r = 1'b1;
    rd   = r;
    rid  = id;
  endtask

  task automatic commit(input logic [4:0] id, input logic [31:0] v);
    en_c = 1'b1;
    qc   = id;
    vc   = v;
  endtask

  function automatic bit is_live(input logic [4:0] id);
    for (int i = 1; i < 32; i++)
      if (m_tag[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int j;
    bit found;
    rst = 1'b0;
    idle();
    model_reset();
    rs1 = 5'd5;
    rs2 = 5'd31;
    cyc();
    cyc();
    chk_ports("reset");
    chk("reset.Qj16", 32'(qj), 32'd16);
    chk("reset.Vk0", vk, 32'd0);
    rst = 1'b1;

    // Rename x3 <- 7, then commit 7 with bypass, then stored
    rename(5'd3, 5'd7);
    cyc();
    rs1 = 5'd3;
    rs2 = 5'd0;
    chk_ports("ren_x3");
    chk("ren_x3.tag", 32'(qj), 32'd7);
    commit(5'd7, 32'hDEADBEEF);
    chk_ports("bypass_x3");
    chk("bypass_x3.V", vj, 32'hDEADBEEF);
    chk("bypass_x3.Q", 32'(qj), 32'd16);
    cyc();
    chk_ports("stored_x3");
    chk("stored_x3.V", vj, 32'hDEADBEEF);

    // Re-rename before commit
    rename(5'd4, 5'd2);
    cyc();
    rename(5'd4, 5'd5);
    cyc();
    rs1 = 5'd4;
    commit(5'd2, 32'h11);
    chk_ports("stale_commit");
    chk("stale_commit.Q", 32'(qj), 32'd5);
    cyc();
    chk_ports("after_stale");
    chk("after_stale.V", vj, 32'd0);
    commit(5'd5, 32'h22);
    cyc();
    chk_ports("x4_commit");
    chk("x4_commit.V", vj, 32'h22);

    // Same-cycle commit and rename of x6
    rename(5'd6, 5'd3);
    cyc();
    rename(5'd6, 5'd9);
    commit(5'd3, 32'h44);
    cyc();
    rs1 = 5'd6;
    chk_ports("x6_newtag");
    chk("x6_newtag.Q", 32'(qj), 32'd9);

    // Mispredict with a dropped rename
    rename(5'd1, 5'd1);
    cyc();
    rename(5'd2, 5'd2);
    cyc();
    misp = 1'b1;
    rename(5'd8, 5'd4);
    cyc();
    rs1 = 5'd6;
    rs2 = 5'd8;
    chk_ports("misp_x6_x8");
    chk("misp.x6V", vj, 32'h44);
    chk("misp.x8Q", 32'(qk), 32'd16);
    rs1 = 5'd1;
    rs2 = 5'd2;
    chk_ports("misp_x1_x2");
    rs1 = 5'd4;
    rs2 = 5'd3;
    chk_ports("misp_values");

    // x0 rename ignored, rdy low freezes state
    rename(5'd0, 5'd3);
    cyc();
    rs1 = 5'd0;
    chk_ports("x0");
    chk("x0.Q", 32'(qj), 32'd16);
    rdy = 1'b0;
    rename(5'd9, 5'd1);
    cyc();
    rs2 = 5'd9;
    chk_ports("rdy_low");
    chk("rdy_low.Q", 32'(qk), 32'd16);

    // Asynchronous reset in mid-cycle
    rename(5'd10, 5'd11);
    cyc();
    rs1 = 5'd3;
    rs2 = 5'd10;
    chk_ports("pre_async");
    #2;
    rst = 1'b0;
    model_reset();
    chk_ports("async_rst");
    chk("async_rst.Vj", vj, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic with unique live tags
    for (int n = 0; n < 400; n++) begin
      idle();
      rdy  = ($urandom_range(0, 9) != 0);
      misp = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) begin
        j = $urandom_range(1, 31);
        qc = (m_tag[j] != ND) ? m_tag[j] : 5'($urandom_range(0, 15));
        vc = $urandom;
        en_c = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        found = 1'b0;
        for (int t = 0; t < 16 && !found; t++) begin
          rid = 5'($urandom_range(0, 15));
          if (!is_live(rid) && !(en_c && rid == qc)) found = 1'b1;
        end
        en_r = found;
        rd   = 5'($urandom_range(0, 31));
      end
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      chk_ports("rand");
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
